exp1_7_rx: RTL and testbench

- Receive-side counterpart to the exp1_7 action sequencer: consumes the sequencer's strobed bus (x, y, act1, act2, step index i).
- Pairs an act1-captured x with an act2-captured y and returns sum and product on a valid/ready result port.
- Checks step-index ordering and counts completed and dropped transactions.
- Sits between the exp1_7 sequencer and any downstream consumer or checker in the exp1_7 bench.

---
 rtl/exp1_7_pkg.sv | 16 +
 rtl/exp1_7_sat_cnt.sv | 34 +++
 rtl/exp1_7_rx.sv | 139 +++++++++++++
 tb/tb_exp1_7_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exp1_7_pkg.sv
// Shared definitions for the exp1_7 sequencer, receiver and bench:
// default widths and the receiver FSM state encoding.
package exp1_7_pkg;

  localparam int DW_DEF = 8;
  localparam int IW_DEF = 2;
  localparam int CW_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_HAVE_X = 2'd1;
  localparam state_t ST_HAVE_Y = 2'd2;
  localparam state_t ST_OUT    = 2'd3;

endpackage

// File: rtl/exp1_7_sat_cnt.sv
// W-bit event counter; SAT=1 holds at all-ones, SAT=0 wraps to zero.
module exp1_7_sat_cnt #(
  parameter int W   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: assign the default first so every path writes cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(SAT && (&cnt_q))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/exp1_7_rx.sv
// Receiver for the exp1_7 sequencer bus: pairs act1-captured x with act2-captured y,
// presents sum and product on a valid/ready port, checks step order and counts events.
module exp1_7_rx
  import exp1_7_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int IW = IW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   x,
  input  logic [DW-1:0]   y,
  input  logic            act1,
  input  logic            act2,
  input  logic [IW-1:0]   i,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [DW:0]     res_sum,
  output logic [2*DW-1:0] res_prod,
  output logic            seq_err,
  output logic            ovr_err,
  output logic [CW-1:0]   pair_cnt,
  output logic [CW-1:0]   drop_cnt
);

  state_t            state_q, state_d;
  logic [DW-1:0]     x_q, x_d;
  logic [DW-1:0]     y_q, y_d;
  logic [IW-1:0]     exp_i_q, exp_i_d;
  logic [DW:0]       sum_q, sum_d;
  logic [2*DW-1:0]   prod_q, prod_d;
  logic              seq_err_q, seq_err_d;
  logic              ovr_err_q, ovr_err_d;
  logic              pair_inc;
  logic              drop_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      exp_i_q   <= '0;
      sum_q     <= '0;
      prod_q    <= '0;
      seq_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      exp_i_q   <= exp_i_d;
      sum_q     <= sum_d;
      prod_q    <= prod_d;
      seq_err_q <= seq_err_d;
      ovr_err_q <= ovr_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    exp_i_d   = exp_i_q;
    sum_d     = sum_q;
    prod_d    = prod_q;
    seq_err_d = seq_err_q;
    ovr_err_d = ovr_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (act1) x_d = x;
        if (act2) y_d = y;
        if (act1 && act2)  state_d = ST_OUT;
        else if (act1)     state_d = ST_HAVE_X;
        else if (act2)     state_d = ST_HAVE_Y;
      end
      ST_HAVE_X: begin
        if (act1) begin
          x_d       = x;
          ovr_err_d = 1'b1;
        end
        if (act2) begin
          y_d     = y;
          state_d = ST_OUT;
        end
      end
      ST_HAVE_Y: begin
        // act1 completes the pair; y is only refreshed by a lone act2
        if (act1) begin
          x_d     = x;
          state_d = ST_OUT;
        end else if (act2) begin
          y_d = y;
        end
      end
      ST_OUT: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Step check resynchronises to the observed index whether or not it matched
    if (act1 && (state_q != ST_OUT)) begin
      if (i != exp_i_q) seq_err_d = 1'b1;
      exp_i_d = i + IW'(1);
    end

    if ((state_q != ST_OUT) && (state_d == ST_OUT)) begin
      sum_d  = {1'b0, x_d} + {1'b0, y_d};
      prod_d = {{DW{1'b0}}, x_d} * {{DW{1'b0}}, y_d};
    end
  end

  always_comb begin
    res_valid = (state_q == ST_OUT);
    pair_inc  = res_valid && res_ready;
    drop_inc  = res_valid && (act1 || act2);
    res_sum   = sum_q;
    res_prod  = prod_q;
    seq_err   = seq_err_q;
    ovr_err   = ovr_err_q;
  end

  exp1_7_sat_cnt #(.W(CW), .SAT(1'b0)) u_pair_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pair_inc),
    .cnt_o (pair_cnt)
  );

  exp1_7_sat_cnt #(.W(CW), .SAT(1'b1)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (drop_inc),
    .cnt_o (drop_cnt)
  );

endmodule

// File: tb/tb_exp1_7_rx.sv
// Scoreboard bench for exp1_7_rx: directed scenarios plus random traffic,
// checked against a transaction-level model of the pairing rules.
module tb_exp1_7_rx;

  logic        clk;
  logic        rst;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        act1;
  logic        act2;
  logic [1:0]  i;
  logic        res_valid;
  logic        res_ready;
  logic [8:0]  res_sum;
  logic [15:0] res_prod;
  logic        seq_err;
  logic        ovr_err;
  logic [7:0]  pair_cnt;
  logic [7:0]  drop_cnt;

  exp1_7_rx dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .y         (y),
    .act1      (act1),
    .act2      (act2),
    .i         (i),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_prod  (res_prod),
    .seq_err   (seq_err),
    .ovr_err   (ovr_err),
    .pair_cnt  (pair_cnt),
    .drop_cnt  (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int sum;
    int prod;
  } result_t;

  result_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Transaction-level model state
  bit m_have_x, m_have_y, m_busy, m_seq, m_ovr;
  int m_x, m_y, m_pair, m_drop, m_expi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have_x = 0; m_have_y = 0; m_busy = 0; m_seq = 0; m_ovr = 0;
    m_x = 0; m_y = 0; m_pair = 0; m_drop = 0; m_expi = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input bit r, input bit a1, input bit a2,
                            input int xv, input int yv, input int iv, input bit rdy);
    result_t res;
    if (r) begin
      model_reset();
    end else if (m_busy) begin
      if (a1 || a2) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      if (rdy) begin
        m_busy = 0;
        m_pair = (m_pair + 1) % 256;
      end
    end else begin
      if (a1) begin
        if (iv != m_expi) m_seq = 1;
        m_expi = (iv + 1) % 4;
        if (m_have_x) m_ovr = 1;
      end
      // a pending y is refreshed by act2 only when act1 does not complete the pair
      if (a2 && !(m_have_y && a1)) begin
        m_y = yv;
        m_have_y = 1;
      end
      if (a1) begin
        m_x = xv;
        m_have_x = 1;
      end
      if (m_have_x && m_have_y) begin
        res.sum  = m_x + m_y;
        res.prod = m_x * m_y;
        exp_q.push_back(res);
        m_busy = 1;
        m_have_x = 0;
        m_have_y = 0;
      end
    end
  endtask

  // Inputs change 1ns after the edge; the model advances at the edge that consumes them
  task automatic step(input bit r, input bit a1, input bit a2,
                      input int xv, input int yv, input int iv, input bit rdy);
    rst = r; act1 = a1; act2 = a2;
    x = xv[7:0]; y = yv[7:0]; i = iv[1:0]; res_ready = rdy;
    @(posedge clk);
    model_edge(r, a1, a2, xv, yv, iv, rdy);
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares DUT outputs to the model and pops results on handshake
  always @(negedge clk) begin
    check("valid", res_valid, m_busy);
    check("pair_cnt", pair_cnt, m_pair);
    check("drop_cnt", drop_cnt, m_drop);
    check("seq_err", seq_err, m_seq);
    check("ovr_err", ovr_err, m_ovr);
    if (res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        check("res_sum", res_sum, exp_q[0].sum);
        check("res_prod", res_prod, exp_q[0].prod);
        if (res_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; act1 = 1'b0; act2 = 1'b0;
    x = '0; y = '0; i = '0; res_ready = 1'b0;
    model_reset();

    // 1: basic pair after reset
    do_reset(3);
    check("rst_sum", res_sum, 0);
    check("rst_prod", res_prod, 0);
    check("rst_valid", res_valid, 0);
    step(0, 1, 0, 3, 0, 0, 1);
    idle(1);
    step(0, 0, 1, 0, 5, 0, 1);
    check("t1_valid", res_valid, 1);
    check("t1_sum", res_sum, 8);
    check("t1_prod", res_prod, 15);
    idle(1);
    check("t1_valid_drop", res_valid, 0);
    check("t1_pair", pair_cnt, 1);
    check("t1_seq", seq_err, 0);

    // 2: simultaneous strobes, max operands, stalled consumer
    step(0, 1, 1, 255, 255, 1, 0);
    for (int k = 0; k < 4; k++) begin
      check("t2_stall_valid", res_valid, 1);
      check("t2_stall_pair", pair_cnt, 1);
      idle(k == 3);
    end
    check("t2_pair", pair_cnt, 2);
    check("t2_valid_after", res_valid, 0);

    // 3: strobes dropped while holding a result
    step(0, 1, 1, 10, 20, 2, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, k != 1, k != 0, 99, 77, 3, 0);
      idle(0);
    end
    check("t3_drop3", drop_cnt, 3);
    check("t3_sum_held", res_sum, 30);
    check("t3_prod_held", res_prod, 200);
    for (int k = 0; k < 300; k++) step(0, 1, 0, 1, 1, 0, 0);
    check("t3_drop_sat", drop_cnt, 255);
    step(0, 0, 1, 0, 1, 0, 1);
    check("t3_drop_sat_hs", drop_cnt, 255);

    // 4: step-index ordering 0,1,3,0
    do_reset(1);
    begin
      int idx[4] = '{0, 1, 3, 0};
      int want[4] = '{0, 0, 1, 1};
      for (int k = 0; k < 4; k++) begin
        step(0, 1, 0, k + 1, 0, idx[k], 1);
        step(0, 0, 1, 0, 2, 0, 1);
        idle(1);
        check("t4_seq", seq_err, want[k]);
      end
    end

    // 5: overrun by a second act1
    do_reset(1);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 7, 0, 1, 0);
    step(0, 0, 1, 0, 2, 0, 0);
    check("t5_ovr", ovr_err, 1);
    check("t5_sum", res_sum, 9);
    check("t5_prod", res_prod, 14);
    idle(1);

    // 6: reset mid-transaction and with a pending result
    do_reset(1);
    step(0, 1, 0, 4, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("t6a_valid", res_valid, 0);
    check("t6a_pair", pair_cnt, 0);
    step(0, 1, 1, 9, 9, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("t6b_pre_valid", res_valid, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    check("t6b_valid", res_valid, 0);
    check("t6b_drop", drop_cnt, 0);
    check("t6b_sum", res_sum, 0);
    step(0, 1, 0, 6, 0, 0, 1);
    step(0, 0, 1, 0, 7, 0, 1);
    check("t6c_sum", res_sum, 13);
    check("t6c_prod", res_prod, 42);
    check("t6c_seq", seq_err, 0);
    idle(1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, a1, a2, rdy;
      int iv;
      r   = ($urandom_range(0, 499) == 0);
      a1  = ($urandom_range(0, 3) == 0);
      a2  = ($urandom_range(0, 3) == 0);
      rdy = $urandom_range(0, 1);
      iv  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : m_expi;
      step(r, a1, a2, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), iv, rdy);
    end
    for (int k = 0; k < 3; k++) idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
